flap_button: RTL and testbench

Conditions the raw player push-button into the single-cycle `flap` strobe consumed by the bird-physics `game` block. It sits between the board pin and `game.flap`:
- synchronizes the asynchronous button;
- debounces it;
- emits exactly one `flap` pulse per accepted press;
- enforces a minimum spacing between pulses so button chatter or mashing cannot inject back-to-back flaps.

---
 rtl/flap_pkg.sv | 19 +
 rtl/btn_sync2.sv | 27 ++
 rtl/flap_button.sv | 141 ++++++++++++++
 tb/tb_flap_button.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flap_pkg.sv
// Shared types and 100 MHz defaults for the flap button conditioner.
package flap_pkg;

  localparam int unsigned DEBOUNCE_10MS = 1_000_000;
  localparam int unsigned COOLDOWN_20MS = 2_000_000;

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } flap_state_t;

  // Bits needed to hold 0..max_val; never narrower than one bit so a zero maximum stays legal.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
module btn_sync2 #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw pin through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/flap_button.sv
// Turns a raw, bouncy push-button into one single-cycle flap strobe per accepted press,
// with a minimum spacing between strobes.
module flap_button
  import flap_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_20MS,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       enable,
  output logic       flap,
  output logic       pressed,
  output logic [7:0] flap_count,
  output logic [7:0] drop_count
);

  localparam int unsigned DcntW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned CoolW = cnt_width(COOLDOWN_CYCLES);
  localparam logic [DcntW-1:0] DcntMax  = DcntW'(DEBOUNCE_CYCLES);
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOLDOWN_CYCLES);

  logic btn_raw;
  logic s;

  flap_state_t      state_q, state_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic [CoolW-1:0] cool_q, cool_d;
  logic             flap_q, flap_d;
  logic [7:0]       flap_count_q, flap_count_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             accept;
  logic             emit;

  assign btn_raw = btn_in ^ ACTIVE_LOW;

  btn_sync2 #(
    .ResetValue(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(btn_raw),
    .q_o(s)
  );

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (s) begin
          state_d = StPressWait;
          dcnt_d  = DcntW'(1);
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StReleased;
          dcnt_d  = '0;
        end else if (dcnt_q == DcntMax) begin
          state_d = StPressed;
          dcnt_d  = '0;
          accept  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DcntW'(1);
        end
      end
      StPressed: begin
        if (!s) begin
          state_d = StReleaseWait;
          dcnt_d  = DcntW'(1);
        end
      end
      StReleaseWait: begin
        if (s) begin
          state_d = StPressed;
          dcnt_d  = '0;
        end else if (dcnt_q == DcntMax) begin
          state_d = StReleased;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DcntW'(1);
        end
      end
      default: begin
        state_d = StReleased;
        dcnt_d  = '0;
      end
    endcase
  end

  // Emit/drop decision, cooldown countdown and statistics.
  always_comb begin
    emit         = accept && enable && (cool_q == '0);
    flap_d       = emit;
    flap_count_d = flap_count_q;
    drop_count_d = drop_count_q;
    cool_d       = cool_q;
    if (emit) begin
      flap_count_d = flap_count_q + 8'd1;
      cool_d       = CoolLoad;
    end else begin
      // Dropped presses do not restart the cooldown.
      if (cool_q != '0) begin
        cool_d = cool_q - CoolW'(1);
      end
      if (accept && (drop_count_q != 8'hFF)) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReleased;
      dcnt_q       <= '0;
      cool_q       <= '0;
      flap_q       <= 1'b0;
      flap_count_q <= 8'd0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      cool_q       <= cool_d;
      flap_q       <= flap_d;
      flap_count_q <= flap_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign flap       = flap_q;
  assign pressed    = (state_q == StPressed) || (state_q == StReleaseWait);
  assign flap_count = flap_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_flap_button.sv
// Directed bench for flap_button: expected flap strobes are queued by the stimulus and
// matched by a negedge monitor; level/counter checks are made inline.
module tb_flap_button;

  localparam int unsigned Deb   = 4;
  localparam int unsigned CoolA = 8;
  // With Deb=4 a re-press can be accepted no sooner than 10 cycles after a flap,
  // so the second instance uses a longer cooldown to make drops reachable.
  localparam int unsigned CoolB = 16;
  // Input set just after edge N is first sampled at N+1; flap is high after edge N+1+Deb+2.
  localparam int unsigned Lat   = Deb + 3;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  cnt;
  } exp_t;

  logic       tb_clock = 1'b0;
  logic       rst;
  logic       btn_a;
  logic       btn_b;
  logic       enable;
  logic       flap_a, pressed_a, flap_b, pressed_b;
  logic [7:0] fc_a, dc_a, fc_b, dc_b;

  int unsigned cyc = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned n_a = 0;
  int unsigned n_b = 0;

  flap_button #(
    .DEBOUNCE_CYCLES(Deb),
    .COOLDOWN_CYCLES(CoolA),
    .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(tb_clock),
    .rst(rst),
    .btn_in(btn_a),
    .enable(enable),
    .flap(flap_a),
    .pressed(pressed_a),
    .flap_count(fc_a),
    .drop_count(dc_a)
  );

  flap_button #(
    .DEBOUNCE_CYCLES(Deb),
    .COOLDOWN_CYCLES(CoolB),
    .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(tb_clock),
    .rst(rst),
    .btn_in(btn_b),
    .enable(enable),
    .flap(flap_b),
    .pressed(pressed_b),
    .flap_count(fc_b),
    .drop_count(dc_b)
  );

  always #5 tb_clock = ~tb_clock;

  always @(posedge tb_clock) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge tb_clock);
    #1;
  endtask

  task automatic press_a(input bit will_emit);
    exp_t e;
    btn_a = 1'b1;
    if (will_emit) begin
      n_a   = (n_a + 1) % 256;
      e.cyc = cyc + Lat;
      e.cnt = 8'(n_a);
      q_a.push_back(e);
    end
  endtask

  task automatic press_b(input bit will_emit);
    exp_t e;
    btn_b = 1'b0;
    if (will_emit) begin
      n_b   = (n_b + 1) % 256;
      e.cyc = cyc + Lat;
      e.cnt = 8'(n_b);
      q_b.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge tb_clock);
      if (flap_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flap_a_spurious: flap=1 at cycle %0d, required 0", cyc);
        end else begin
          e = q_a.pop_front();
          check("flap_a_cycle", cyc, e.cyc);
          check("flap_a_count", fc_a, e.cnt);
          check("flap_a_pressed", pressed_a, 1);
        end
      end
      if (flap_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flap_b_spurious: flap=1 at cycle %0d, required 0", cyc);
        end else begin
          e = q_b.pop_front();
          check("flap_b_cycle", cyc, e.cyc);
          check("flap_b_count", fc_b, e.cnt);
          check("flap_b_pressed", pressed_b, 1);
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_a  = 1'b0;
    btn_b  = 1'b1;
    enable = 1'b1;
    fork
      monitor();
    join_none
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_flap_a", flap_a, 0);
    check("rst_pressed_a", pressed_a, 0);
    check("rst_fc_a", fc_a, 0);
    check("rst_dc_a", dc_a, 0);
    check("rst_flap_b", flap_b, 0);
    check("rst_pressed_b", pressed_b, 0);
    check("rst_fc_b", fc_b, 0);
    check("rst_dc_b", dc_b, 0);

    // 1. Clean press and release timing
    tick(2);
    press_a(1);
    tick(Lat - 1);
    check("press_pressed_early", pressed_a, 0);
    tick(1);
    check("press_pressed_rise", pressed_a, 1);
    check("press_fc", fc_a, 1);
    tick(3);
    btn_a = 1'b0;
    tick(Lat - 1);
    check("release_pressed_hold", pressed_a, 1);
    tick(1);
    check("release_pressed_fall", pressed_a, 0);
    tick(10);

    // 2. Bounce rejection: 3 high, 1 low, five times
    for (int i = 0; i < 5; i++) begin
      btn_a = 1'b1;
      tick(3);
      btn_a = 1'b0;
      tick(1);
      check("bounce_pressed", pressed_a, 0);
    end
    tick(10);
    check("bounce_pressed_end", pressed_a, 0);
    check("bounce_fc", fc_a, 1);
    check("bounce_dc", dc_a, 0);

    // 3a. Cooldown (active-low instance): re-press accepted one cycle before cool hits 0
    press_b(1);
    tick(7);
    btn_b = 1'b1;
    tick(9);
    press_b(0);
    tick(7);
    check("cool_drop_dc", dc_b, 1);
    btn_b = 1'b1;
    tick(7);
    press_b(1);
    tick(7);
    btn_b = 1'b1;
    tick(10);
    check("cool_fc_b", fc_b, 2);
    check("cool_dc_b", dc_b, 1);
    tick(20);

    // 3b. Re-press accepted on the first cycle with cool == 0
    press_b(1);
    tick(7);
    btn_b = 1'b1;
    tick(10);
    press_b(1);
    tick(7);
    btn_b = 1'b1;
    tick(12);
    check("cool_edge_fc_b", fc_b, 4);
    check("cool_edge_dc_b", dc_b, 1);

    // 4a. enable low only on the accept edge
    press_a(0);
    tick(6);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    check("enable_drop_dc", dc_a, 1);
    btn_a = 1'b0;
    tick(12);

    // 4b. enable low during debounce only, then held for 100 cycles
    enable = 1'b0;
    press_a(1);
    tick(6);
    enable = 1'b1;
    tick(100);
    btn_a = 1'b0;
    tick(12);
    check("hold_fc", fc_a, n_a);
    check("hold_dc", dc_a, 1);

    // 5. Reset while in PRESS_WAIT with the button held
    btn_a = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_flap_a", flap_a, 0);
    check("midrst_pressed_a", pressed_a, 0);
    check("midrst_fc_a", fc_a, 0);
    check("midrst_dc_a", dc_a, 0);
    check("midrst_fc_b", fc_b, 0);
    check("midrst_dc_b", dc_b, 0);
    n_a = 0;
    n_b = 0;
    press_a(1);
    tick(Lat + 5);
    btn_a = 1'b0;
    tick(12);

    // 6. flap_count wraps after 256 emitted flaps since reset
    for (int i = 0; i < 255; i++) begin
      press_a(1);
      tick(8);
      btn_a = 1'b0;
      tick(8);
    end
    tick(5);
    check("wrap_fc", fc_a, 0);
    check("wrap_dc", dc_a, 0);

    // drop_count saturates
    enable = 1'b0;
    for (int i = 0; i < 257; i++) begin
      press_a(0);
      tick(8);
      btn_a = 1'b0;
      tick(8);
    end
    enable = 1'b1;
    check("sat_dc", dc_a, 255);
    check("sat_fc", fc_a, 0);

    tick(5);
    check("missing_flap_a", q_a.size(), 0);
    check("missing_flap_b", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
